// File: rtl/vram_pkg.sv
// Shared constants and FSM state type for the VRAM write arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package vram_pkg;

    localparam int VRAM_DATAW       = 24;
    localparam int VRAM_ADDR_LENGTH = 20;
    localparam int VRAM_TOTAL_PIXEL = 307200;

    // IDLE is only occupied for the first cycle after reset release.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        CLEAR = 2'd2
    } vram_state_e;

endpackage

// File: rtl/vram_rr_arb2.sv
// Two-port round-robin grant with internal priority register.
// Latency: grants are combinational from valids; priority updates on the next edge.
// Backpressure: no grant when en_i is low; a lone valid wins regardless of priority.
module vram_rr_arb2 (
    input  logic clk,
    input  logic resetN,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o
);

    // prio_q == 0 means port 0 wins a contended cycle.
    logic prio_q;
    logic prio_d;
    logic contend;

    assign contend = en_i & valid0_i & valid1_i;

    // Grant decode: priority only matters when both ports ask.
    always_comb begin
        grant0_o = en_i & valid0_i & (~valid1_i | ~prio_q);
        grant1_o = en_i & valid1_i & (~valid0_i |  prio_q);
    end

    // Priority moves to the other port after every contended grant.
    always_comb begin
        prio_d = contend ? ~prio_q : prio_q;
    end

    // Priority register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates two pixel writers onto one VRAM write port and runs full-frame clears.
// Latency: accepted transfers and clear writes appear on the VRAM port 1 cycle later.
// Backpressure: reqReady held low outside ARB; one write per cycle sustained.
// Optional: define VRAM_ARB_ADDR_CHECK_EN to drop out-of-frame writes and pulse addrErr.
module vram_write_arbiter
    import vram_pkg::*;
#(
    parameter int DATAW      = VRAM_DATAW,
    parameter int addrLength = VRAM_ADDR_LENGTH,
    parameter int totalPixel = VRAM_TOTAL_PIXEL
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  reqValid0,
    input  logic                  reqValid1,
    input  logic [addrLength-1:0] reqAddr0,
    input  logic [addrLength-1:0] reqAddr1,
    input  logic [DATAW-1:0]      reqData0,
    input  logic [DATAW-1:0]      reqData1,
    output logic                  reqReady0,
    output logic                  reqReady1,
    input  logic                  clearStart,
    input  logic [DATAW-1:0]      clearColor,
    output logic                  clearBusy,
    output logic                  clearDone,
    output logic                  writeEn,
    output logic [addrLength-1:0] writePointer,
`ifdef VRAM_ARB_ADDR_CHECK_EN
    output logic                  addrErr,
`endif
    output logic [DATAW-1:0]      dataIn
);

    localparam logic [addrLength-1:0] LAST_ADDR = addrLength'(totalPixel - 1);

    vram_state_e           state_q, state_d;
    logic [addrLength-1:0] cnt_q, cnt_d;
    logic [DATAW-1:0]      color_q, color_d;
    logic                  we_q, we_d;
    logic [addrLength-1:0] ptr_q, ptr_d;
    logic [DATAW-1:0]      dat_q, dat_d;
    logic                  done_q, done_d;
`ifdef VRAM_ARB_ADDR_CHECK_EN
    logic                  err_q, err_d;
`endif

    logic                  arb_en;
    logic                  grant0;
    logic                  grant1;
    logic [addrLength-1:0] sel_addr;
    logic [DATAW-1:0]      sel_data;
    logic                  clear_last;

    assign arb_en     = (state_q == ARB);
    assign clear_last = (state_q == CLEAR) && (cnt_q == LAST_ADDR);
    assign sel_addr   = grant1 ? reqAddr1 : reqAddr0;
    assign sel_data   = grant1 ? reqData1 : reqData0;

    vram_rr_arb2 u_rr_arb (
        .clk      (clk),
        .resetN   (resetN),
        .en_i     (arb_en),
        .valid0_i (reqValid0),
        .valid1_i (reqValid1),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    // Next-state: one IDLE cycle after reset, clears run until the last address is issued.
    always_comb begin
        state_d = state_q;
        color_d = color_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                state_d = ARB;
            end
            ARB: begin
                if (clearStart) begin
                    state_d = CLEAR;
                    color_d = clearColor;
                end
            end
            CLEAR: begin
                if (clear_last) begin
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-port next values: clear fill has the port, otherwise the granted requester.
    always_comb begin
        we_d   = 1'b0;
        ptr_d  = ptr_q;
        dat_d  = dat_q;
        done_d = clear_last;
`ifdef VRAM_ARB_ADDR_CHECK_EN
        err_d  = 1'b0;
`endif
        if (state_q == CLEAR) begin
            we_d  = 1'b1;
            ptr_d = cnt_q;
            dat_d = color_q;
        end else if (grant0 || grant1) begin
`ifdef VRAM_ARB_ADDR_CHECK_EN
            // Out-of-frame requests are still accepted so the requester never stalls.
            if (sel_addr > LAST_ADDR) begin
                err_d = 1'b1;
            end else begin
                we_d  = 1'b1;
                ptr_d = sel_addr;
                dat_d = sel_data;
            end
`else
            we_d  = 1'b1;
            ptr_d = sel_addr;
            dat_d = sel_data;
`endif
        end
    end

    // State, clear counter/colour and registered VRAM port.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            ptr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
`ifdef VRAM_ARB_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            we_q    <= we_d;
            ptr_q   <= ptr_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
`ifdef VRAM_ARB_ADDR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign reqReady0    = grant0;
    assign reqReady1    = grant1;
    assign clearBusy    = (state_q == CLEAR);
    assign clearDone    = done_q;
    assign writeEn      = we_q;
    assign writePointer = ptr_q;
    assign dataIn       = dat_q;
`ifdef VRAM_ARB_ADDR_CHECK_EN
    assign addrErr      = err_q;
`endif

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: directed scenarios plus randomized traffic.
// Latency: checks writes one cycle after acceptance.
// Backpressure: requesters hold valid and observe reqReady.
module tb_vram_write_arbiter;

    localparam int DW    = 24;
    localparam int AW    = 8;
    localparam int TOTAL = 16;

    logic          clk = 1'b0;
    logic          resetN;
    logic          reqValid0, reqValid1;
    logic [AW-1:0] reqAddr0, reqAddr1;
    logic [DW-1:0] reqData0, reqData1;
    logic          reqReady0, reqReady1;
    logic          clearStart;
    logic [DW-1:0] clearColor;
    logic          clearBusy, clearDone;
    logic          writeEn;
    logic [AW-1:0] writePointer;
    logic [DW-1:0] dataIn;
`ifdef VRAM_ARB_ADDR_CHECK_EN
    logic          addrErr;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    vram_write_arbiter #(.DATAW(DW), .addrLength(AW), .totalPixel(TOTAL)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .reqValid0    (reqValid0),
        .reqValid1    (reqValid1),
        .reqAddr0     (reqAddr0),
        .reqAddr1     (reqAddr1),
        .reqData0     (reqData0),
        .reqData1     (reqData1),
        .reqReady0    (reqReady0),
        .reqReady1    (reqReady1),
        .clearStart   (clearStart),
        .clearColor   (clearColor),
        .clearBusy    (clearBusy),
        .clearDone    (clearDone),
        .writeEn      (writeEn),
        .writePointer (writePointer),
`ifdef VRAM_ARB_ADDR_CHECK_EN
        .addrErr      (addrErr),
`endif
        .dataIn       (dataIn)
    );

    task automatic idle_inputs();
        reqValid0  = 1'b0;
        reqValid1  = 1'b0;
        reqAddr0   = '0;
        reqAddr1   = '0;
        reqData0   = '0;
        reqData1   = '0;
        clearStart = 1'b0;
        clearColor = '0;
    endtask

    // Returns at a falling edge with reset just released (the IDLE cycle).
    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        idle_inputs();
        reqValid0 = 1'b1;
        reqValid1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (writeEn !== 1'b0) begin n_miss++; $display("FAIL reset_we got=%b exp=0", writeEn); end
        n_vec++; if (writePointer !== '0) begin n_miss++; $display("FAIL reset_ptr got=%0h exp=0", writePointer); end
        n_vec++; if (dataIn !== '0) begin n_miss++; $display("FAIL reset_data got=%0h exp=0", dataIn); end
        n_vec++; if ({reqReady1, reqReady0} !== 2'b00) begin n_miss++; $display("FAIL reset_ready got=%b exp=00", {reqReady1, reqReady0}); end
        n_vec++; if ({clearBusy, clearDone} !== 2'b00) begin n_miss++; $display("FAIL reset_clear got=%b exp=00", {clearBusy, clearDone}); end
        // First cycle after release is IDLE: no grants yet.
        @(negedge clk);
        resetN = 1'b1;
        #1;
        n_vec++; if ({reqReady1, reqReady0} !== 2'b00) begin n_miss++; $display("FAIL idle_ready got=%b exp=00", {reqReady1, reqReady0}); end
        @(negedge clk);
        #1;
        n_vec++; if ({reqReady1, reqReady0} !== 2'b01) begin n_miss++; $display("FAIL arb_first_ready got=%b exp=01", {reqReady1, reqReady0}); end
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        reqValid0 = 1'b1;
        reqAddr0  = 8'd5;
        reqData0  = 24'hABCDEF;
        #1;
        n_vec++; if ({reqReady1, reqReady0} !== 2'b01) begin n_miss++; $display("FAIL single_ready got=%b exp=01", {reqReady1, reqReady0}); end
        @(negedge clk);
        reqValid0 = 1'b0;
        #1;
        n_vec++; if (writeEn !== 1'b1) begin n_miss++; $display("FAIL single_we got=%b exp=1", writeEn); end
        n_vec++; if (writePointer !== 8'd5) begin n_miss++; $display("FAIL single_ptr got=%0d exp=5", writePointer); end
        n_vec++; if (dataIn !== 24'hABCDEF) begin n_miss++; $display("FAIL single_data got=%0h exp=abcdef", dataIn); end
        @(negedge clk);
        #1;
        n_vec++; if (writeEn !== 1'b0) begin n_miss++; $display("FAIL single_we_after got=%b exp=0", writeEn); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_ptr;
        int            g;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            reqValid0 = (i < 4);
            reqValid1 = (i < 4);
            reqAddr0  = AW'(10 + i);
            reqAddr1  = AW'(20 + i);
            reqData0  = DW'(24'h100 + i);
            reqData1  = DW'(24'h200 + i);
            #1;
            if (i < 4) begin
                g = i % 2;
                n_vec++;
                if ({reqReady1, reqReady0} !== ((g == 0) ? 2'b01 : 2'b10)) begin
                    n_miss++; $display("FAIL rr_grant%0d got=%b exp_port=%0d", i, {reqReady1, reqReady0}, g);
                end
            end
            if (i > 0) begin
                g = (i - 1) % 2;
                exp_ptr = (g == 0) ? AW'(10 + i - 1) : AW'(20 + i - 1);
                n_vec++;
                if (writeEn !== 1'b1 || writePointer !== exp_ptr) begin
                    n_miss++; $display("FAIL rr_write%0d got=%b/%0d exp=1/%0d", i, writeEn, writePointer, exp_ptr);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clear();
        logic          e_busy, e_rdy, e_done;
        logic [AW-1:0] e_ptr;
        logic [DW-1:0] e_dat;
        do_reset();
        @(negedge clk);
        clearStart = 1'b1;
        clearColor = 24'h112233;
        reqValid0  = 1'b1;
        reqAddr0   = 8'd3;
        reqData0   = 24'h000055;
        #1;
        n_vec++; if (reqReady0 !== 1'b1) begin n_miss++; $display("FAIL clear_same_cycle_ready got=%b exp=1", reqReady0); end
        @(negedge clk);
        clearStart = 1'b0;
        clearColor = 24'hFFFFFF;
        reqAddr0   = 8'd4;
        reqData0   = 24'h000066;
        for (int k = 0; k < 18; k++) begin
            #1;
            e_busy = (k <= TOTAL - 1);
            e_rdy  = (k >= TOTAL);
            e_done = (k == TOTAL);
            if (k == 0) begin
                e_ptr = 8'd3;  e_dat = 24'h000055;
            end else if (k <= TOTAL) begin
                e_ptr = AW'(k - 1); e_dat = 24'h112233;
            end else begin
                e_ptr = 8'd4;  e_dat = 24'h000066;
            end
            n_vec++;
            if (clearBusy !== e_busy || reqReady0 !== e_rdy || clearDone !== e_done) begin
                n_miss++; $display("FAIL clear_ctl%0d got busy/rdy/done=%b%b%b exp=%b%b%b", k, clearBusy, reqReady0, clearDone, e_busy, e_rdy, e_done);
            end
            n_vec++;
            if (writeEn !== 1'b1 || writePointer !== e_ptr || dataIn !== e_dat) begin
                n_miss++; $display("FAIL clear_wr%0d got=%b/%0d/%0h exp=1/%0d/%0h", k, writeEn, writePointer, dataIn, e_ptr, e_dat);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_during_clear();
        bit found = 0;
        do_reset();
        @(negedge clk);
        clearStart = 1'b1;
        clearColor = 24'h0A0B0C;
        @(negedge clk);
        clearStart = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (writeEn === 1'b1 && writePointer === 8'd7) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_vec++; if (!found) begin n_miss++; $display("FAIL rstclr_reach7 got=timeout exp=write_to_7"); end
        resetN = 1'b0;
        #1;
        n_vec++; if (writeEn !== 1'b0 || clearBusy !== 1'b0) begin n_miss++; $display("FAIL rstclr_abort got we/busy=%b%b exp=00", writeEn, clearBusy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) resetN = 1'b1;
            #1;
            n_vec++; if (clearDone !== 1'b0 || writeEn !== 1'b0) begin n_miss++; $display("FAIL rstclr_quiet%0d got done/we=%b%b exp=00", i, clearDone, writeEn); end
        end
        @(negedge clk);
        reqValid1 = 1'b1;
        reqAddr1  = 8'd9;
        reqData1  = 24'h000077;
        #1;
        n_vec++; if ({reqReady1, reqReady0} !== 2'b10) begin n_miss++; $display("FAIL rstclr_ready got=%b exp=10", {reqReady1, reqReady0}); end
        @(negedge clk);
        reqValid1 = 1'b0;
        #1;
        n_vec++; if (writeEn !== 1'b1 || writePointer !== 8'd9 || dataIn !== 24'h000077) begin
            n_miss++; $display("FAIL rstclr_write got=%b/%0d/%0h exp=1/9/77", writeEn, writePointer, dataIn);
        end
    endtask

`ifdef VRAM_ARB_ADDR_CHECK_EN
    task automatic test_addr_check();
        do_reset();
        @(negedge clk);
        reqValid0 = 1'b1;
        reqAddr0  = 8'd20;
        reqData0  = 24'h123456;
        #1;
        n_vec++; if (reqReady0 !== 1'b1) begin n_miss++; $display("FAIL addrchk_ready got=%b exp=1", reqReady0); end
        @(negedge clk);
        reqValid0 = 1'b0;
        #1;
        n_vec++; if (writeEn !== 1'b0 || addrErr !== 1'b1) begin n_miss++; $display("FAIL addrchk_err got we/err=%b%b exp=01", writeEn, addrErr); end
        @(negedge clk);
        #1;
        n_vec++; if (addrErr !== 1'b0) begin n_miss++; $display("FAIL addrchk_pulse got=%b exp=0", addrErr); end
    endtask
`endif

    // Reference model: tracks "ready to serve", remaining clear pixels and whose turn it is.
    task automatic test_random();
        bit            m_idle = 1;
        int            m_rem  = 0;
        int            m_turn = 0;
        logic [DW-1:0] m_color = '0;
        bit            e_we = 0, e_done = 0, e_err = 0;
        logic [AW-1:0] e_ptr = '0;
        logic [DW-1:0] e_dat = '0;
        bit            serving;
        int            winner;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reqValid0  = ($urandom_range(0, 1) == 1);
            reqValid1  = ($urandom_range(0, 1) == 1);
            reqAddr0   = AW'($urandom_range(0, 31));
            reqAddr1   = AW'($urandom_range(0, 31));
            reqData0   = DW'($urandom);
            reqData1   = DW'($urandom);
            clearStart = ($urandom_range(0, 29) == 0);
            clearColor = DW'($urandom);
            #1;
            serving = !m_idle && (m_rem == 0);
            winner  = -1;
            if (serving) begin
                if (reqValid0 && reqValid1) winner = m_turn;
                else if (reqValid0)         winner = 0;
                else if (reqValid1)         winner = 1;
            end
            n_vec++;
            if (reqReady0 !== (winner == 0) || reqReady1 !== (winner == 1)) begin
                n_miss++; $display("FAIL rnd_ready c=%0d got=%b%b exp_winner=%0d", c, reqReady1, reqReady0, winner);
            end
            n_vec++;
            if (writeEn !== e_we || (e_we && (writePointer !== e_ptr || dataIn !== e_dat))) begin
                n_miss++; $display("FAIL rnd_write c=%0d got=%b/%0h/%0h exp=%b/%0h/%0h", c, writeEn, writePointer, dataIn, e_we, e_ptr, e_dat);
            end
            n_vec++;
            if (clearBusy !== (m_rem > 0) || clearDone !== e_done) begin
                n_miss++; $display("FAIL rnd_clear c=%0d got busy/done=%b%b exp=%b%b", c, clearBusy, clearDone, (m_rem > 0), e_done);
            end
`ifdef VRAM_ARB_ADDR_CHECK_EN
            n_vec++;
            if (addrErr !== e_err) begin n_miss++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, addrErr, e_err); end
`endif
            e_we = 0; e_done = 0; e_err = 0;
            if (m_rem > 0) begin
                e_we  = 1;
                e_ptr = AW'(TOTAL - m_rem);
                e_dat = m_color;
                m_rem--;
                e_done = (m_rem == 0);
            end else if (winner >= 0) begin
                e_ptr = (winner == 0) ? reqAddr0 : reqAddr1;
                e_dat = (winner == 0) ? reqData0 : reqData1;
                e_we  = 1;
`ifdef VRAM_ARB_ADDR_CHECK_EN
                if (int'(e_ptr) >= TOTAL) begin
                    e_we  = 0;
                    e_err = 1;
                end
`endif
            end
            if (serving && reqValid0 && reqValid1) m_turn = 1 - m_turn;
            if (serving && clearStart) begin
                m_rem   = TOTAL;
                m_color = clearColor;
            end
            m_idle = 0;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_clear();
        test_reset_during_clear();
`ifdef VRAM_ARB_ADDR_CHECK_EN
        test_addr_check();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
